uart_tx_fifo: RTL

- Byte FIFO plus issue sequencer, directly upstream of uart_tx.
- Accepts bytes from producer logic (message generators, debug taps) at full clock rate.
- Drives uart_tx's data-valid/byte inputs, one byte per frame, paced by uart_tx's active/done outputs.
- Producers therefore never handshake with the serializer directly.

---
 rtl/uart_tx_fifo.sv | 137 +++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding uart_tx: producers enqueue at full clock rate, and the
// sequencer issues one byte per frame, paced by uart_tx's active/done outputs.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Wr_En,
  input  logic [7:0]        i_Wr_Byte,
  input  logic              i_Clear_Ovf,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic [1:0]        o_State
);

  // Handshake: a byte is accepted when i_Wr_En=1 and o_Full=0 at the clock
  // edge; a byte is handed downstream by a one-cycle o_Tx_DV pulse with
  // o_Tx_Byte valid alongside it and held until the next pulse.

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    GAP       = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_next;
  logic              push;
  logic              drop;
  logic              launch;
  logic              pop;
  logic              dv_next;
  logic [7:0]        byte_next;
  state_t            state;
  state_t            state_next;

  // Fullness is judged on the registered flag, so a same-cycle pop never rescues a write.
  assign push    = i_Wr_En && !o_Full;
  assign drop    = i_Wr_En && o_Full;
  assign launch  = !o_Empty && !i_Tx_Active;
  assign o_State = state;

  always_comb begin
    count_next = o_Count;
    if (push && !pop) begin
      count_next = o_Count + CNT_ONE;
    end else if (pop && !push) begin
      count_next = o_Count - CNT_ONE;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) begin
      mem[wr_ptr] <= i_Wr_Byte;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_Count    <= '0;
      o_Empty    <= 1'b1;
      o_Full     <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      o_Count <= count_next;
      o_Empty <= (count_next == '0);
      o_Full  <= (count_next == CNT_FULL);
      // A new overflow outranks a clear in the same cycle.
      if (drop) begin
        o_Overflow <= 1'b1;
      end else if (i_Clear_Ovf) begin
        o_Overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (launch) state_next = WAIT_DONE;
      WAIT_DONE: if (i_Tx_Done) state_next = GAP;
      GAP:       state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    dv_next   = 1'b0;
    byte_next = o_Tx_Byte;
    if (state == IDLE && launch) begin
      pop       = 1'b1;
      dv_next   = 1'b1;
      byte_next = mem[rd_ptr];
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
    end else begin
      o_Tx_DV   <= dv_next;
      o_Tx_Byte <= byte_next;
    end
  end

endmodule
